// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU/writeback types, flag indices and entry layout
package alu_pkg;
   localparam int WB_BW = 16;
   localparam int WB_AW = 3;
   typedef enum logic [1:0] {ONZ_Z = 2'd0, ONZ_N = 2'd1, ONZ_O = 2'd2} onz_idx_e;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
      OP_XOR = 3'b100, OP_INC = 3'b101, OP_MOV = 3'b110, OP_MOV_ALT = 3'b111
   } alu_op_e;
   typedef struct packed {
      logic [WB_BW-1:0] result;
      logic [2:0]       onz;
      logic [WB_AW-1:0] rd;
      logic             flag_we;
   } wb_entry_t;
   function automatic int entry_w(input int bw, input int aw);
      return bw + 3 + aw + 1;
   endfunction
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: 2-entry valid/ready FIFO, no push-through when full
module wb_fifo2 #(parameter int W = 23) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [W-1:0] mem [2];
   logic wr_ptr, rd_ptr, push, pop;
   logic [1:0] count;
   assign in_ready  = count != 2'd2;
   assign out_valid = count != 2'd0;
   assign out_data  = mem[rd_ptr];
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end
   always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_data;
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: buffers ALU results and retires them into the register file and flags
module alu_writeback
   import alu_pkg::*;
#(
   parameter int BW   = WB_BW,
   parameter int NREG = 8,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] in_result,
   input  logic [2:0]    in_onz,
   input  logic [AW-1:0] in_rd,
   input  logic          in_flag_we,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [BW-1:0] ext_data,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [BW-1:0] ra_data,
   output logic [BW-1:0] rb_data,
   output logic [2:0]    flags,
   output logic          pending,
   output logic [AW-1:0] pending_rd
);
   typedef struct packed {
      logic [BW-1:0] result;
      logic [2:0]    onz;
      logic [AW-1:0] rd;
      logic          flag_we;
   } entry_t;
   entry_t in_e, head;
   logic head_valid, retire;
   logic [BW-1:0] rf [NREG];
   assign in_e = '{result: in_result, onz: in_onz, rd: in_rd, flag_we: in_flag_we};
   assign retire = head_valid & ~ext_we;
   wb_fifo2 #(.W(entry_w(BW, AW))) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_e),
      .out_valid(head_valid), .out_ready(~ext_we), .out_data(head)
   );
   assign pending    = head_valid;
   assign pending_rd = head_valid ? head.rd : '0;
   assign ra_data    = rf[ra_addr];
   assign rb_data    = rf[rb_addr];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
         flags <= 3'b000;
      end else begin
         if (ext_we && ext_addr != '0) rf[ext_addr] <= ext_data;
         else if (retire && head.rd != '0) rf[head.rd] <= head.result;
         if (retire && head.flag_we) flags <= head.onz;
      end
   end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU. Accepts each ALU result with its ONZ flags and destination register through a valid/ready handshake, and buffers it in a 2-entry FIFO. The head entry retires into an internal register file and the architectural flag register. Two combinational read ports source the ALU's `in_a`/`in_b`. A higher-priority external write port (load path) can steal the register-file write slot.

## Interface
Parameters:
- `BW`, 16, datapath width; must match ALU `BW`.
- `NREG`, 8, number of registers; power of two, ≥2.
- `AW`, `$clog2(NREG)`, register address width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU result valid.
- `in_ready`  out  1  stage can accept; equals `count != 2`.
- `in_result`  in  BW  ALU `result`.
- `in_onz`  in  3  ALU `onz_flags`: [0]=Z, [1]=N, [2]=O.
- `in_rd`  in  AW  destination register.
- `in_flag_we`  in  1  1 = update flag register on retire.
- `ext_we`  in  1  external write request; has priority over the FIFO.
- `ext_addr`  in  AW  external write address.
- `ext_data`  in  BW  external write data.
- `ra_addr`, `rb_addr`  in  AW  read addresses.
- `ra_data`, `rb_data`  out  BW  combinational read data from the array.
- `flags`  out  3  architectural ONZ flag register.
- `pending`  out  1  FIFO non-empty; upstream uses it for hazard stall.
- `pending_rd`  out  AW  destination of the head entry; 0 when empty.

## Operation
- FIFO: 2 entries, each holding {result, onz, rd, flag_we}. State is `wr_ptr`, `rd_ptr` (1 bit each) and `count` (0..2).
- Push when `in_valid & in_ready`.
- Pop (retire) when `count != 0 & ~ext_we`.
- Retire writes `rf[head.rd] <= head.result` and, if `head.flag_we`, `flags <= head.onz`.
- A write to address 0 is discarded for both the FIFO and ext paths; `rf[0]` always reads 0.
- `ext_we` writes `rf[ext_addr] <= ext_data` that cycle and stalls retire. Flags are never affected by ext writes.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- When full, `in_ready = 0`, even if a pop occurs in the same cycle. There is no push-through.
- Retirement is strictly in order: FIFO order equals ALU issue order.
- Reads return array contents only; no bypass from the FIFO or the ext port. Upstream must stall on `pending`.
- No other state machine: the FIFO is the only control state.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - rf all 0, `flags = 3'b000`, `count = 0`, pointers 0.
  - Outputs: `in_ready = 1`, `pending = 0`, `pending_rd = 0`.
- Reset mid-operation discards buffered entries; none retire.
- Latency: an entry accepted at edge k retires at edge k+1 at the earliest, provided `ext_we = 0` in cycle k+1.
  - The written value is visible on the read ports combinationally after edge k+1.
- Each cycle `ext_we` is held postpones retire by one cycle. Sustained `ext_we` fills the FIFO, then deasserts `in_ready`.
- Throughput: 1 result per cycle with `ext_we = 0`.
- Empty FIFO: no write and no flag change, regardless of `in_*` values.

## Structure
- `alu_pkg` holds:
  - `onz_idx_e` flag bit indices (Z=0, N=1, O=2).
  - The ALU opcode enumeration: ADD=000, SUB=001, AND=010, OR=011, XOR=100, INC=101, MOV=110/111.
  - A `wb_entry_t` packed struct {result, onz, rd, flag_we}, parameterised via BW/AW localparams.
- Sub-module `wb_fifo2`: a 2-entry valid/ready FIFO of `wb_entry_t`, parameterised on entry width.
- The register file and flag register stay in `alu_writeback`.

## Test plan
- Reset, then push `{result=16'h1234, rd=3, onz=000, flag_we=1}`.
  - Expect `pending = 1`, `pending_rd = 3` for one cycle.
  - Next edge: `ra_addr = 3` returns `16'h1234`, `flags = 000`, `pending = 0`.
- Back-to-back pushes of 4 entries (rd 1..4, data `16'hA001`..`16'hA004`) with `in_valid` held high.
  - Expect `in_ready` stays 1 and each value retires exactly one cycle after its acceptance.
- Hold `ext_we = 1` (addr 5, data `16'hBEEF`) for 4 cycles while pushing 3 entries.
  - Expect the third push blocked (`in_ready = 0` at `count = 2`) and rf[5] = `16'hBEEF`.
  - After `ext_we` drops, entries retire in order over 2 cycles.
- Push `{rd=0, result=16'hFFFF, onz=010, flag_we=1}`.
  - Expect rf[0] still reads 0 and `flags = 010`.
- Push `{rd=2, onz=101, flag_we=0}` after `flags = 010`.
  - Expect rf[2] updated and `flags` unchanged at 010.
- Fill the FIFO (2 entries), assert `rst_n = 0` mid-cycle.
  - Expect `in_ready = 1`, `pending = 0`, `flags = 000` immediately, and neither destination register written.
